// File: rtl/voice_allocator_if.sv
// Request/assignment bundle between the MIDI decoder, the voice allocator and the voice array.
// The master side issues note requests and envelope status; the slave side is the allocator.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 32,
    parameter int V_WIDTH    = 5,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7
);
    logic                  req_valid;
    logic                  req_on;
    logic [NOTE_WIDTH-1:0] req_note;
    logic [VEL_WIDTH-1:0]  req_vel;
    logic                  ready;
    logic                  sustain;
    logic [NUM_VOICES-1:0] env_idle;
    logic                  assign_valid;
    logic [V_WIDTH-1:0]    assign_voice;
    logic [NOTE_WIDTH-1:0] assign_note;
    logic [VEL_WIDTH-1:0]  assign_vel;
    logic                  assign_steal;
    logic                  assign_retrig;
    logic                  assign_drop;
    logic [NUM_VOICES-1:0] keys_on;
    logic [NUM_VOICES-1:0] voice_free;
    logic [V_WIDTH:0]      active_keys;

    modport master (
        output req_valid, req_on, req_note, req_vel, sustain, env_idle,
        input  ready, assign_valid, assign_voice, assign_note, assign_vel,
               assign_steal, assign_retrig, assign_drop, keys_on, voice_free, active_keys
    );

    modport slave (
        input  req_valid, req_on, req_note, req_vel, sustain, env_idle,
        output ready, assign_valid, assign_voice, assign_note, assign_vel,
               assign_steal, assign_retrig, assign_drop, keys_on, voice_free, active_keys
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off requests onto NUM_VOICES voices with
// oldest-first stealing, sustain pedal handling and per-voice status for the synth core.
module voice_allocator #(
    parameter int NUM_VOICES = 32,
    parameter int V_WIDTH    = 5,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7,
    parameter bit STEAL_MODE = 1'b1
) (
    input  logic             reg_clk,
    input  logic             reset_reg_n,
    voice_allocator_if.slave bus
);

    typedef enum logic [1:0] {V_FREE, V_HELD, V_SUSTAINED, V_RELEASING} voiceState_e;
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} fsmState_e;
    typedef enum logic [1:0] {K_RETRIG, K_FREE, K_STEAL, K_DROP} targetKind_e;

    localparam logic [V_WIDTH-1:0] AGE_MAX = V_WIDTH'(NUM_VOICES - 1);

    fsmState_e             fsm_q, fsm_d;
    logic                  reqOn_q, reqOn_d;
    logic [NOTE_WIDTH-1:0] reqNote_q, reqNote_d;
    logic [VEL_WIDTH-1:0]  reqVel_q, reqVel_d;
    logic [V_WIDTH-1:0]    target_q, target_d;
    targetKind_e           kind_q, kind_d;
    logic                  sustain_q;

    voiceState_e           voiceState_q [NUM_VOICES];
    voiceState_e           voiceState_d [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] voiceNote_q  [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] voiceNote_d  [NUM_VOICES];
    logic [V_WIDTH-1:0]    voiceAge_q   [NUM_VOICES];
    logic [V_WIDTH-1:0]    voiceAge_d   [NUM_VOICES];

    logic                  assignValid_q, assignValid_d;
    logic [V_WIDTH-1:0]    assignVoice_q, assignVoice_d;
    logic [NOTE_WIDTH-1:0] assignNote_q, assignNote_d;
    logic [VEL_WIDTH-1:0]  assignVel_q, assignVel_d;
    logic                  assignSteal_q, assignSteal_d;
    logic                  assignRetrig_q, assignRetrig_d;
    logic                  assignDrop_q, assignDrop_d;
    logic [V_WIDTH:0]      activeKeys_q, activeKeys_d;

    logic                  matchFound, freeFound, relFound, keyFound;
    logic [V_WIDTH-1:0]    matchIdx, freeIdx, relIdx, keyIdx;
    logic [V_WIDTH-1:0]    relAge, keyAge;
    logic [V_WIDTH-1:0]    searchIdx;
    targetKind_e           searchKind;

    logic                  inCommit, commitOn, commitOff, commitDrop, sustainFall;
    logic [NUM_VOICES-1:0] keysOn, voiceFree;

    assign inCommit    = (fsm_q == S_COMMIT);
    assign commitOn    = inCommit && reqOn_q && (kind_q != K_DROP);
    assign commitDrop  = inCommit && reqOn_q && (kind_q == K_DROP);
    assign commitOff   = inCommit && !reqOn_q;
    assign sustainFall = sustain_q && !bus.sustain;

    always_ff @(posedge reg_clk) begin
        if (!reset_reg_n) begin
            fsm_q     <= S_IDLE;
            reqOn_q   <= 1'b0;
            reqNote_q <= '0;
            reqVel_q  <= '0;
            target_q  <= '0;
            kind_q    <= K_DROP;
            sustain_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            reqOn_q   <= reqOn_d;
            reqNote_q <= reqNote_d;
            reqVel_q  <= reqVel_d;
            target_q  <= target_d;
            kind_q    <= kind_d;
            sustain_q <= bus.sustain;
        end
    end

    // A note-on with zero velocity is folded into a note-off at acceptance.
    always_comb begin
        fsm_d     = fsm_q;
        reqOn_d   = reqOn_q;
        reqNote_d = reqNote_q;
        reqVel_d  = reqVel_q;
        target_d  = target_q;
        kind_d    = kind_q;
        case (fsm_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    fsm_d     = S_SEARCH;
                    reqOn_d   = bus.req_on && (bus.req_vel != '0);
                    reqNote_d = bus.req_note;
                    reqVel_d  = bus.req_vel;
                end
            end
            S_SEARCH: begin
                fsm_d    = S_COMMIT;
                target_d = searchIdx;
                kind_d   = searchKind;
            end
            S_COMMIT: fsm_d = S_IDLE;
            default:  fsm_d = S_IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on age ties.
    always_comb begin
        matchFound = 1'b0;
        matchIdx   = '0;
        freeFound  = 1'b0;
        freeIdx    = '0;
        relFound   = 1'b0;
        relIdx     = '0;
        relAge     = '0;
        keyFound   = 1'b0;
        keyIdx     = '0;
        keyAge     = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            case (voiceState_q[v])
                V_FREE: begin
                    if (!freeFound) begin
                        freeFound = 1'b1;
                        freeIdx   = V_WIDTH'(v);
                    end
                end
                V_RELEASING: begin
                    if (!relFound || voiceAge_q[v] > relAge) begin
                        relFound = 1'b1;
                        relIdx   = V_WIDTH'(v);
                        relAge   = voiceAge_q[v];
                    end
                end
                default: begin
                    if (!matchFound && voiceNote_q[v] == reqNote_q) begin
                        matchFound = 1'b1;
                        matchIdx   = V_WIDTH'(v);
                    end
                    if (!keyFound || voiceAge_q[v] > keyAge) begin
                        keyFound = 1'b1;
                        keyIdx   = V_WIDTH'(v);
                        keyAge   = voiceAge_q[v];
                    end
                end
            endcase
        end
    end

    always_comb begin
        searchIdx  = '0;
        searchKind = K_DROP;
        if (matchFound) begin
            searchIdx  = matchIdx;
            searchKind = K_RETRIG;
        end else if (freeFound) begin
            searchIdx  = freeIdx;
            searchKind = K_FREE;
        end else if (STEAL_MODE && relFound) begin
            searchIdx  = relIdx;
            searchKind = K_STEAL;
        end else if (STEAL_MODE && keyFound) begin
            searchIdx  = keyIdx;
            searchKind = K_STEAL;
        end
    end

    // Committing a note-on to a voice wins over any release event on that voice in the same cycle.
    always_comb begin
        activeKeys_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voiceState_d[v] = voiceState_q[v];
            voiceNote_d[v]  = voiceNote_q[v];
            voiceAge_d[v]   = voiceAge_q[v];
            case (voiceState_q[v])
                V_HELD: begin
                    if (commitOff && voiceNote_q[v] == reqNote_q) begin
                        voiceState_d[v] = bus.sustain ? V_SUSTAINED : V_RELEASING;
                    end
                end
                V_SUSTAINED: begin
                    if (sustainFall) voiceState_d[v] = V_RELEASING;
                end
                V_RELEASING: begin
                    if (bus.env_idle[v]) voiceState_d[v] = V_FREE;
                end
                default: ;
            endcase
            if (commitOn) begin
                if (V_WIDTH'(v) == target_q) begin
                    voiceState_d[v] = V_HELD;
                    voiceNote_d[v]  = reqNote_q;
                    voiceAge_d[v]   = '0;
                end else if (voiceState_q[v] != V_FREE && voiceAge_q[v] != AGE_MAX) begin
                    voiceAge_d[v] = voiceAge_q[v] + V_WIDTH'(1);
                end
            end
            if (voiceState_d[v] == V_HELD || voiceState_d[v] == V_SUSTAINED) begin
                activeKeys_d = activeKeys_d + (V_WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge reg_clk) begin
        if (!reset_reg_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                voiceState_q[v] <= V_FREE;
                voiceNote_q[v]  <= '0;
                voiceAge_q[v]   <= '0;
            end
            activeKeys_q <= '0;
        end else begin
            voiceState_q <= voiceState_d;
            voiceNote_q  <= voiceNote_d;
            voiceAge_q   <= voiceAge_d;
            activeKeys_q <= activeKeys_d;
        end
    end

    always_comb begin
        assignValid_d  = commitOn;
        assignDrop_d   = commitDrop;
        assignSteal_d  = commitOn && (kind_q == K_STEAL);
        assignRetrig_d = commitOn && (kind_q == K_RETRIG);
        assignVoice_d  = assignVoice_q;
        assignNote_d   = assignNote_q;
        assignVel_d    = assignVel_q;
        if (commitOn) begin
            assignVoice_d = target_q;
            assignNote_d  = reqNote_q;
            assignVel_d   = reqVel_q;
        end
    end

    always_ff @(posedge reg_clk) begin
        if (!reset_reg_n) begin
            assignValid_q  <= 1'b0;
            assignVoice_q  <= '0;
            assignNote_q   <= '0;
            assignVel_q    <= '0;
            assignSteal_q  <= 1'b0;
            assignRetrig_q <= 1'b0;
            assignDrop_q   <= 1'b0;
        end else begin
            assignValid_q  <= assignValid_d;
            assignVoice_q  <= assignVoice_d;
            assignNote_q   <= assignNote_d;
            assignVel_q    <= assignVel_d;
            assignSteal_q  <= assignSteal_d;
            assignRetrig_q <= assignRetrig_d;
            assignDrop_q   <= assignDrop_d;
        end
    end

    always_comb begin
        keysOn    = '0;
        voiceFree = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            keysOn[v]    = (voiceState_q[v] == V_HELD) || (voiceState_q[v] == V_SUSTAINED);
            voiceFree[v] = (voiceState_q[v] == V_FREE);
        end
    end

    assign bus.ready         = (fsm_q == S_IDLE);
    assign bus.assign_valid  = assignValid_q;
    assign bus.assign_voice  = assignVoice_q;
    assign bus.assign_note   = assignNote_q;
    assign bus.assign_vel    = assignVel_q;
    assign bus.assign_steal  = assignSteal_q;
    assign bus.assign_retrig = assignRetrig_q;
    assign bus.assign_drop   = assignDrop_q;
    assign bus.keys_on       = keysOn;
    assign bus.voice_free    = voiceFree;
    assign bus.active_keys   = activeKeys_q;

endmodule
